// File: rtl/ptw_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ptw_mem_arbiter
//
// Shares one page-table-walk read port between the instruction-side MMU (IF)
// and the load/store-side MMU (LS). One transaction is outstanding at a time.
// Grants are round-robin on conflict. The read response is passed straight
// through to the owning requester. An owner flush turns the in-flight read
// into a drain: the response is swallowed and neither side sees it.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   if_req_i / ls_req_i      level PTE read request, held until *_rvalid_o
//   if_addr_i / ls_addr_i    PTE address, stable while request is high
//   if_flush_i / ls_flush_i  walk cancel pulse
//   if_rdata_o / ls_rdata_o  PTE data (valid with *_rvalid_o)
//   if_rvalid_o/ls_rvalid_o  one-cycle response strobe
//   if_err_o / ls_err_o      bus error, qualified by *_rvalid_o
//   mem_ar*                  read address channel (valid/ready)
//   mem_r*                   read data channel (no backpressure)
//   busy_o                   arbiter is not idle
//   owner_o                  current or last grant (0 = IF, 1 = LS)
// ---------------------------------------------------------------------------
module ptw_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_rvalid_o,
    output logic              if_err_o,

    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic              ls_flush_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_rvalid_o,
    output logic              ls_err_o,

    output logic              mem_arvalid_o,
    output logic [ADDR_W-1:0] mem_araddr_o,
    input  logic              mem_arready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [1:0]        mem_rresp_i,

    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_owner;     // 0 = IF, 1 = LS
    logic              r_rr_last;   // last winner; the other side wins a tie
    logic              r_cancel;    // owner flushed while the address was pending
    logic [ADDR_W-1:0] r_araddr;

    logic              w_if_elig;
    logic              w_ls_elig;
    logic              w_grant;
    logic              w_winner;
    logic              w_owner_flush;
    logic              w_rvalid;
    logic              w_err;

    // A request flushed in the same cycle is not a candidate for the grant.
    assign w_if_elig     = if_req_i && !if_flush_i;
    assign w_ls_elig     = ls_req_i && !ls_flush_i;
    assign w_grant       = w_if_elig || w_ls_elig;
    assign w_winner      = (w_if_elig && w_ls_elig) ? ~r_rr_last : w_ls_elig;

    // Only the current owner's flush matters; the other side's is ignored.
    assign w_owner_flush = r_owner ? ls_flush_i : if_flush_i;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                // The address phase always completes; a flush seen here only
                // redirects the data phase into a drain.
                if (mem_arready_i) begin
                    w_state_nxt = (r_cancel || w_owner_flush) ? S_DRAIN : S_DATA;
                end
            end
            S_DATA: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_owner_flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Grant bookkeeping and cancel flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr  <= '0;
            r_owner   <= 1'b0;
            r_rr_last <= 1'b1;
            r_cancel  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_grant) begin
                r_araddr  <= w_winner ? ls_addr_i : if_addr_i;
                r_owner   <= w_winner;
                r_rr_last <= w_winner;
            end

            if (w_state_nxt == S_IDLE) begin
                r_cancel <= 1'b0;
            end else if (r_state == S_ADDR && w_owner_flush) begin
                r_cancel <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The response is suppressed if the owner flushes in the same cycle.
    assign w_rvalid = mem_rvalid_i && !w_owner_flush && !r_cancel;
    assign w_err    = (mem_rresp_i != 2'b00);

    always_comb begin
        mem_arvalid_o = (r_state == S_ADDR);
        mem_araddr_o  = r_araddr;
        busy_o        = (r_state != S_IDLE);
        owner_o       = r_owner;

        if_rvalid_o   = 1'b0;
        if_rdata_o    = '0;
        if_err_o      = 1'b0;
        ls_rvalid_o   = 1'b0;
        ls_rdata_o    = '0;
        ls_err_o      = 1'b0;

        if (r_state == S_DATA) begin
            if (r_owner) begin
                ls_rvalid_o = w_rvalid;
                ls_rdata_o  = mem_rdata_i;
                ls_err_o    = w_err;
            end else begin
                if_rvalid_o = w_rvalid;
                if_rdata_o  = mem_rdata_i;
                if_err_o    = w_err;
            end
        end
    end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ptw_mem_arbiter
//
// Randomised two-requester / one-memory environment around ptw_mem_arbiter.
// The memory model pushes each response it issues into a scoreboard queue;
// a negedge monitor tracks grants at transaction level (who was eligible,
// who won last) and pops the queue to check routing, suppression and data.
// ---------------------------------------------------------------------------
module tb_ptw_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;

    logic          t_req   [2];
    logic          t_flush [2];
    logic [AW-1:0] t_addr  [2];

    logic          if_req_i, ls_req_i, if_flush_i, ls_flush_i;
    logic [AW-1:0] if_addr_i, ls_addr_i;
    logic [DW-1:0] if_rdata_o, ls_rdata_o;
    logic          if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o;
    logic          mem_arvalid_o, mem_arready_i, mem_rvalid_i;
    logic [AW-1:0] mem_araddr_o;
    logic [DW-1:0] mem_rdata_i;
    logic [1:0]    mem_rresp_i;
    logic          busy_o, owner_o;

    assign if_req_i   = t_req[0];
    assign ls_req_i   = t_req[1];
    assign if_flush_i = t_flush[0];
    assign ls_flush_i = t_flush[1];
    assign if_addr_i  = t_addr[0];
    assign ls_addr_i  = t_addr[1];

    always #5 clk = ~clk;

    ptw_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_flush_i    (if_flush_i),
        .if_rdata_o    (if_rdata_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_err_o      (if_err_o),
        .ls_req_i      (ls_req_i),
        .ls_addr_i     (ls_addr_i),
        .ls_flush_i    (ls_flush_i),
        .ls_rdata_o    (ls_rdata_o),
        .ls_rvalid_o   (ls_rvalid_o),
        .ls_err_o      (ls_err_o),
        .mem_arvalid_o (mem_arvalid_o),
        .mem_araddr_o  (mem_araddr_o),
        .mem_arready_i (mem_arready_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rresp_i   (mem_rresp_i),
        .busy_o        (busy_o),
        .owner_o       (owner_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor / reference model (transaction level)
    // -----------------------------------------------------------------------
    logic          m_busy, m_addrph, m_last, m_owner, m_fl;
    logic [AW-1:0] m_addr;
    logic          p_if_el, p_ls_el, p_rvalid;
    logic [AW-1:0] p_if_addr, p_ls_addr;
    logic          s_hs, s_arvalid;
    logic          got [2];
    logic          busy_now, ok;
    rsp_t          it;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_arvalid", mem_arvalid_o, 1'b0);
            chkw("rst_araddr",  mem_araddr_o,  32'h0);
            chk1("rst_busy",    busy_o,        1'b0);
            chk1("rst_owner",   owner_o,       1'b0);
            chk1("rst_if_rv",   if_rvalid_o,   1'b0);
            chk1("rst_ls_rv",   ls_rvalid_o,   1'b0);
            chk1("rst_if_err",  if_err_o,      1'b0);
            chk1("rst_ls_err",  ls_err_o,      1'b0);
            chkw("rst_if_rd",   if_rdata_o,    32'h0);
            chkw("rst_ls_rd",   ls_rdata_o,    32'h0);
            m_busy = 1'b0; m_addrph = 1'b0; m_last = 1'b1; m_owner = 1'b0;
            m_fl = 1'b0; m_addr = '0;
            p_if_el = 1'b0; p_ls_el = 1'b0; p_rvalid = 1'b0;
            p_if_addr = '0; p_ls_addr = '0;
            s_hs = 1'b0; s_arvalid = 1'b0; got[0] = 1'b0; got[1] = 1'b0;
        end else begin
            // Busy starts the cycle after an idle cycle with an eligible
            // request, and ends the cycle after the memory response.
            busy_now = m_busy ? !p_rvalid : (p_if_el || p_ls_el);
            if (!m_busy && busy_now) begin
                m_owner  = (p_if_el && p_ls_el) ? !m_last : p_ls_el;
                m_last   = m_owner;
                m_addr   = m_owner ? p_ls_addr : p_if_addr;
                m_addrph = 1'b1;
                m_fl     = 1'b0;
            end

            chk1("busy", busy_o, busy_now);
            chk1("arvalid", mem_arvalid_o, busy_now && m_addrph);
            chk1("owner", owner_o, m_owner);
            if (busy_now && m_addrph) chkw("araddr", mem_araddr_o, m_addr);

            if (busy_now) m_fl = m_fl | (m_owner ? ls_flush_i : if_flush_i);

            if (mem_rvalid_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got rvalid with no expected entry at %0t", $time);
                end else begin
                    it = sb_q.pop_front();
                    ok = !m_fl;
                    chk1("if_rvalid", if_rvalid_o, ok && !m_owner);
                    chk1("ls_rvalid", ls_rvalid_o, ok && m_owner);
                    if (ok && !m_owner) begin
                        chkw("if_rdata", if_rdata_o, it.data);
                        chk1("if_err",   if_err_o,   it.err);
                        chk1("ls_err_q", ls_err_o,   1'b0);
                    end else if (ok) begin
                        chkw("ls_rdata", ls_rdata_o, it.data);
                        chk1("ls_err",   ls_err_o,   it.err);
                        chk1("if_err_q", if_err_o,   1'b0);
                    end
                end
            end else begin
                chk1("if_rvalid_quiet", if_rvalid_o, 1'b0);
                chk1("ls_rvalid_quiet", ls_rvalid_o, 1'b0);
            end

            if (busy_now && m_addrph && mem_arready_i) m_addrph = 1'b0;
            m_busy    = busy_now;
            p_rvalid  = mem_rvalid_i;
            p_if_el   = if_req_i && !if_flush_i;
            p_ls_el   = ls_req_i && !ls_flush_i;
            p_if_addr = if_addr_i;
            p_ls_addr = ls_addr_i;
            s_hs      = mem_arvalid_o && mem_arready_i;
            s_arvalid = mem_arvalid_o;
            got[0]    = if_rvalid_o;
            got[1]    = ls_rvalid_o;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus: requesters and memory
    // -----------------------------------------------------------------------
    logic pend;
    int   cnt;
    logic hold_ar;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [DW-1:0] d, input logic [1:0] r);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        mem_rresp_i  = r;
        sb_q.push_back(rsp_t'{data: d, err: (r != 2'b00)});
    endtask

    task automatic req_step(input logic active);
        for (int unsigned s = 0; s < 2; s++) begin
            if (t_flush[s]) begin
                t_flush[s] = 1'b0;
                t_req[s]   = 1'b0;
            end else if (t_req[s] && got[s]) begin
                t_req[s] = 1'b0;
            end else if (t_req[s] && active && ($urandom % 20 == 0)) begin
                t_flush[s] = 1'b1;
            end
            if (!active) begin
                t_req[s]   = 1'b0;
                t_flush[s] = 1'b0;
            end else if (!t_req[s] && !t_flush[s] && ($urandom % 3 == 0)) begin
                t_req[s]  = 1'b1;
                t_addr[s] = $urandom;
            end
        end
    endtask

    task automatic mem_step();
        if (s_hs) begin
            pend = 1'b1;
            cnt  = $urandom_range(0, 3);
        end
        if (pend && cnt == 0) begin
            push_rsp($urandom, ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            pend = 1'b0;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rresp_i  = 2'b00;
            if (pend) cnt--;
        end
        mem_arready_i = hold_ar ? 1'b0 : 1'($urandom % 2);
    endtask

    initial begin
        rst = 1'b1;
        for (int unsigned s = 0; s < 2; s++) begin
            t_req[s] = 1'b0; t_flush[s] = 1'b0; t_addr[s] = '0;
        end
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = '0; mem_rresp_i = 2'b00;
        pend = 1'b0; cnt = 0; hold_ar = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single IF read, response four cycles after the request is seen.
        tick();                                   // cycle 0
        t_req[0] = 1'b1; t_addr[0] = 32'h8000_1000; mem_arready_i = 1'b1;
        tick();                                   // cycle 1
        #1;
        chk1("t1_arvalid", mem_arvalid_o, 1'b1);
        chkw("t1_araddr",  mem_araddr_o,  32'h8000_1000);
        tick(); tick();                           // cycles 2, 3
        tick();                                   // cycle 4
        push_rsp(32'h2000_00CF, 2'b00);
        #1;
        chk1("t1_if_rvalid", if_rvalid_o, 1'b1);
        chkw("t1_if_rdata",  if_rdata_o,  32'h2000_00CF);
        chk1("t1_ls_rvalid", ls_rvalid_o, 1'b0);
        tick();                                   // cycle 5
        mem_rvalid_i = 1'b0; t_req[0] = 1'b0;
        #1 chk1("t1_busy_fall", busy_o, 1'b0);

        // LS read that returns a bus error.
        tick();
        t_req[1] = 1'b1; t_addr[1] = 32'h0000_4440;
        tick();
        tick();
        push_rsp(32'h1234_5678, 2'b10);
        #1;
        chk1("t5_ls_rvalid", ls_rvalid_o, 1'b1);
        chk1("t5_ls_err",    ls_err_o,    1'b1);
        chk1("t5_if_err",    if_err_o,    1'b0);
        tick();
        mem_rvalid_i = 1'b0; mem_rresp_i = 2'b00; t_req[1] = 1'b0;
        tick();

        // Random traffic with flushes and address backpressure.
        repeat (3000) begin
            tick(); req_step(1'b1); mem_step();
        end

        // Park the arbiter in the address phase, then reset it there.
        hold_ar = 1'b1;
        for (int i = 0; i < 500 && !s_arvalid; i++) begin
            tick(); req_step(1'b1); mem_step();
        end
        chk1("reach_addr_phase", s_arvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("arst_arvalid", mem_arvalid_o, 1'b0);
        chk1("arst_busy",    busy_o,        1'b0);
        for (int unsigned s = 0; s < 2; s++) begin
            t_req[s] = 1'b0; t_flush[s] = 1'b0;
        end
        mem_rvalid_i = 1'b0; mem_rresp_i = 2'b00; pend = 1'b0; hold_ar = 1'b0;
        sb_q.delete();
        tick(); tick();
        t_req[0] = 1'b1; t_addr[0] = 32'hA000_0010;
        t_req[1] = 1'b1; t_addr[1] = 32'hB000_0020;
        mem_arready_i = 1'b0;
        #2 rst = 1'b0;
        tick();
        #1;
        chk1("post_rst_arvalid", mem_arvalid_o, 1'b1);
        chk1("post_rst_owner",   owner_o,       1'b0);
        chkw("post_rst_araddr",  mem_araddr_o,  32'hA000_0010);

        repeat (400) begin
            tick(); req_step(1'b1); mem_step();
        end
        repeat (40) begin
            tick(); req_step(1'b0); mem_step();
        end
        chkw("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/ptw_mem_arbiter.md
Name: ptw_mem_arbiter

Overview:
- Shares one page-table-walk memory read port between the instruction-side MMU (IF) and the load/store-side MMU (LS).
- Each MMU holds a level request with an address until it receives a one-cycle read-valid response.
- The arbiter grants one requester at a time using round-robin, issues a single read with a valid/ready address handshake, and routes the response back to the owner.
- When the owner is flushed, the arbiter drains and discards the in-flight response.

Parameters:
- ADDR_W, 32, physical address width of PTE reads.
- DATA_W, 32, PTE data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  IF MMU PTE read request; level, held until if_rvalid_o.
- if_addr_i  in  ADDR_W  IF PTE address; stable while if_req_i is high.
- if_flush_i  in  1  cancel the IF walk; pulse.
- if_rdata_o  out  DATA_W  PTE data to IF.
- if_rvalid_o  out  1  one-cycle response to IF.
- if_err_o  out  1  bus error on the IF response; qualified by if_rvalid_o.
- ls_req_i, ls_addr_i, ls_flush_i, ls_rdata_o, ls_rvalid_o, ls_err_o  same widths and meaning as the IF ports, for the LS MMU.
- mem_arvalid_o  out  1  read address valid.
- mem_araddr_o  out  ADDR_W  read address.
- mem_arready_i  in  1  memory accepts the address.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_W  read data.
- mem_rresp_i  in  2  read response; non-zero means error.
- busy_o  out  1  state is not IDLE.
- owner_o  out  1  current or last grant: 0 = IF, 1 = LS.

Behaviour:
- States: IDLE, ADDR, DATA, DRAIN. One outstanding transaction at most; no read-data buffering.
- Reset (async, any state, including mid-transaction):
  - state = IDLE; mem_arvalid_o = 0; mem_araddr_o = 0.
  - All rvalid/err outputs = 0; rdata outputs = 0.
  - busy_o = 0; owner_o = 0; rr_last = 1, so IF wins the first conflict.
  - The memory side must also be reset; the arbiter does not track transactions across reset.
- IDLE:
  - Only IF requests: grant IF. Only LS requests: grant LS.
  - Both request: grant the requester not equal to rr_last.
  - On a grant: latch the address into mem_araddr_o, set owner_o and rr_last to the winner, set mem_arvalid_o = 1, go to ADDR.
  - A request whose own flush is asserted in the same cycle is not eligible.
- ADDR:
  - mem_arvalid_o and mem_araddr_o are held stable until mem_arready_i is sampled high.
  - On the handshake: mem_arvalid_o = 0 next cycle; go to DATA, or to DRAIN if the owner was flushed in ADDR or in this cycle.
  - An owner flush in ADDR never drops mem_arvalid_o early; it sets a cancel flag.
- DATA:
  - Responses are combinational pass-through, with no added latency:
    - {owner}_rvalid_o = mem_rvalid_i && !owner_flush && !cancel.
    - {owner}_rdata_o = mem_rdata_i.
    - {owner}_err_o = (mem_rresp_i != 0).
  - Non-owner outputs stay 0.
  - On mem_rvalid_i: go to IDLE.
  - Owner flush with no rvalid: go to DRAIN.
  - Flush coincident with rvalid: response suppressed, go to IDLE.
- DRAIN: wait for mem_rvalid_i, discard it (no rvalid_o to either side), go to IDLE.
- Flush rules:
  - A flush of the non-owner has no effect.
  - A flush in IDLE has no effect.
  - Cancel flag clears on return to IDLE.
- Requester contract: the requester drops req the cycle after rvalid unless it is issuing a new request. The arbiter re-arbitrates on the first IDLE cycle after completion, so back-to-back grants have a one-cycle bubble.
- Minimum latency (req seen at cycle 0, arready and rvalid immediate):
  - cycle 1: arvalid high.
  - cycle 2: state DATA.
  - rvalid_o in the same cycle as mem_rvalid_i.
- Fairness: with both requesting continuously, grants alternate IF, LS, IF, LS.

Test Plan:
1. Single IF request, if_addr_i = 0x8000_1000, arready at cycle 1, rvalid with rdata 0x2000_00CF at cycle 4 -> mem_araddr_o = 0x8000_1000 with arvalid high at cycle 1; if_rvalid_o = 1 and if_rdata_o = 0x2000_00CF at cycle 4; ls_rvalid_o stays 0; busy_o falls at cycle 5.
2. IF and LS both requesting from reset, each response on the second DATA cycle -> grant order IF, LS, IF, LS; owner_o toggles; each requester gets exactly one rvalid per grant.
3. Memory holds arready = 0 for 5 cycles -> arvalid held and mem_araddr_o unchanged for all 5 cycles; LS requesting meanwhile is not granted.
4. IF granted, if_flush_i pulsed in DATA before rvalid, rvalid 3 cycles later with 0xDEAD_BEEF -> state goes to DRAIN; if_rvalid_o never asserts; IDLE after the rvalid; a pending LS request is granted next.
5. LS response with mem_rresp_i = 2'b10 -> ls_rvalid_o = 1 and ls_err_o = 1 in the same cycle; if_err_o = 0.
6. rst asserted asynchronously mid-ADDR -> mem_arvalid_o = 0 and busy_o = 0 immediately; after release with both requesting, IF is granted first.
